// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
// Shared definitions for the vector assembler and the vector register it
// feeds: vector length, element-index width, and the assembler state
// encoding. Also provides a small helper to detect the final slot.
// -----------------------------------------------------------------------------
package vector_pkg;

    // Number of elements per packed vector
    localparam int VEC_LEN = 4;

    // Width of the element index counter
    localparam int IDX_W = 2;

    // Index value of the last slot in a vector
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

    // Assembler states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // True when the given index addresses the final slot of a vector
    function automatic logic is_last_slot(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX);
    endfunction

endpackage

// File: rtl/vector_assembler.sv
// -----------------------------------------------------------------------------
// vector_assembler
// Collects a serial stream of elements over a valid/ready handshake and packs
// every VEC_LEN elements into one vector. A full vector is presented on
// vec_out with a one-cycle load strobe for the vector register's write port.
// Framing on in_last is checked: a short frame is dropped with an err pulse;
// a long frame is still loaded (first VEC_LEN elements) with err raised
// alongside load, and the surplus elements are drained up to in_last.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-low reset
//   flush     in   discard any partial vector, return to IDLE
//   in_valid  in   element present on in_data
//   in_data   in   element value (ELEM_WIDTH bits)
//   in_last   in   marks the final element of a vector
//   in_ready  out  element can be accepted this cycle (state decode only)
//   vec_out   out  packed vector, element 0 in the LSB slot
//   load      out  one-cycle write strobe, registered
//   busy      out  state is not IDLE, registered
//   err       out  one-cycle framing-error pulse, registered
// -----------------------------------------------------------------------------
module vector_assembler
    import vector_pkg::*;
#(
    parameter int ELEM_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [ELEM_WIDTH-1:0]         in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [VEC_LEN*ELEM_WIDTH-1:0] vec_out,
    output logic                          load,
    output logic                          busy,
    output logic                          err
);

    localparam int VEC_W = VEC_LEN * ELEM_WIDTH;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 long_q, long_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic                 load_q, load_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 accept_s;

    // Ready is a pure state decode: only the COMMIT bubble blocks input
    always_comb begin
        in_ready = (state_q != COMMIT);
    end

    // Handshake completion
    always_comb begin
        accept_s = in_valid & in_ready;
    end

    // Next-state, packing and registered-output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        long_d  = long_q;
        vec_d   = vec_q;
        err_d   = 1'b0;

        if (flush) begin
            // Flush beats any accept in the same cycle and never flags err
            state_d = IDLE;
            idx_d   = {IDX_W{1'b0}};
            long_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, FILL: begin
                    if (accept_s) begin
                        for (int i = 0; i < VEC_LEN; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                vec_d[i*ELEM_WIDTH +: ELEM_WIDTH] = in_data;
                            end else begin
                                vec_d[i*ELEM_WIDTH +: ELEM_WIDTH] = vec_q[i*ELEM_WIDTH +: ELEM_WIDTH];
                            end
                        end
                        if (is_last_slot(idx_q)) begin
                            // Vector complete; a missing in_last means the
                            // frame runs long and must be drained afterwards
                            state_d = COMMIT;
                            idx_d   = {IDX_W{1'b0}};
                            long_d  = ~in_last;
                        end else if (in_last) begin
                            // Short frame: drop the partial vector
                            state_d = IDLE;
                            idx_d   = {IDX_W{1'b0}};
                            err_d   = 1'b1;
                        end else begin
                            state_d = FILL;
                            idx_d   = idx_q + 2'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                COMMIT: begin
                    // The long-frame flag has been reported with load; clear it
                    if (long_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                    long_d = 1'b0;
                end
                DRAIN: begin
                    // Surplus elements are discarded without packing
                    if (accept_s && in_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = {IDX_W{1'b0}};
                    long_d  = 1'b0;
                end
            endcase
        end

        // Long-frame error is reported in the same cycle as load
        if ((state_d == COMMIT) && long_d) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        load_d = (state_d == COMMIT);
        busy_d = (state_d != IDLE);
    end

    // State, counter, data and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            long_q  <= 1'b0;
            vec_q   <= {VEC_W{1'b0}};
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            long_q  <= long_d;
            vec_q   <= vec_d;
            load_q  <= load_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Drive outputs straight from flops
    always_comb begin
        vec_out = vec_q;
        load    = load_q;
        err     = err_q;
        busy    = busy_q;
    end

endmodule

// File: tb/tb_vector_assembler.sv
module tb_vector_assembler;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [15:0] vec_out;
    logic        load;
    logic        busy;
    logic        err;

    int n_vec;
    int n_err;

    vector_assembler #(.ELEM_WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .vec_out  (vec_out),
        .load     (load),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element, wait (bounded) for ready, complete the accept
    task automatic send(input logic [3:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check_val("ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [3:0]  stream [8];
    logic [15:0] b2b_exp [2];

    initial begin
        int ptr;
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_last  = 1'b0;
        stream   = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        b2b_exp  = '{16'h8765, 16'hCBA9};

        // Reset values
        tick();
        tick();
        check_val("rst_load",  32'(load), 32'd0);
        check_val("rst_err",   32'(err), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_vec",   32'(vec_out), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        tick();
        check_val("post_rst_ready", 32'(in_ready), 32'd1);

        // Basic vector 1,2,3,4
        send(4'h1, 1'b0);
        check_val("basic_nold1", 32'(load), 32'd0);
        check_val("basic_busy1", 32'(busy), 32'd1);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        check_val("basic_nold3", 32'(load), 32'd0);
        send(4'h4, 1'b1);
        check_val("basic_load",  32'(load), 32'd1);
        check_val("basic_vec",   32'(vec_out), 32'h4321);
        check_val("basic_err",   32'(err), 32'd0);
        check_val("basic_rdy0",  32'(in_ready), 32'd0);
        tick();
        check_val("basic_load_end", 32'(load), 32'd0);
        check_val("basic_rdy1",     32'(in_ready), 32'd1);
        check_val("basic_idle",     32'(busy), 32'd0);
        check_val("basic_vec_hold", 32'(vec_out), 32'h4321);

        // Back-to-back vectors with in_valid held high
        ptr = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = stream[ptr % 8];
            in_last = ((ptr % 4) == 3);
            check_val("b2b_ready", 32'(in_ready), ((k % 5) == 4) ? 32'd0 : 32'd1);
            if (in_ready) ptr++;
            tick();
            check_val("b2b_load", 32'(load), ((k % 5) == 3) ? 32'd1 : 32'd0);
            if ((k % 5) == 3) check_val("b2b_vec", 32'(vec_out), 32'(b2b_exp[k / 5]));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_val("b2b_count", 32'(ptr), 32'd8);

        // Short frame 5,6 then 1,2,3,4
        send(4'h5, 1'b0);
        send(4'h6, 1'b1);
        check_val("short_err",  32'(err), 32'd1);
        check_val("short_nold", 32'(load), 32'd0);
        check_val("short_idle", 32'(busy), 32'd0);
        tick();
        check_val("short_err_end", 32'(err), 32'd0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b1);
        check_val("short_next_load", 32'(load), 32'd1);
        check_val("short_next_vec",  32'(vec_out), 32'h4321);
        check_val("short_next_err",  32'(err), 32'd0);
        tick();

        // Long frame A..F, in_last on F
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        send(4'hD, 1'b0);
        check_val("long_load", 32'(load), 32'd1);
        check_val("long_err",  32'(err), 32'd1);
        check_val("long_vec",  32'(vec_out), 32'hDCBA);
        tick();
        check_val("drain_ready", 32'(in_ready), 32'd1);
        check_val("drain_busy",  32'(busy), 32'd1);
        check_val("drain_err",   32'(err), 32'd0);
        check_val("drain_load",  32'(load), 32'd0);
        send(4'hE, 1'b0);
        check_val("drain_e_busy", 32'(busy), 32'd1);
        check_val("drain_e_vec",  32'(vec_out), 32'hDCBA);
        check_val("drain_e_err",  32'(err), 32'd0);
        send(4'hF, 1'b1);
        check_val("drain_f_idle", 32'(busy), 32'd0);
        check_val("drain_f_vec",  32'(vec_out), 32'hDCBA);
        check_val("drain_f_err",  32'(err), 32'd0);

        // Flush after 2 elements; flush wins over a simultaneous accept
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("flush_idle", 32'(busy), 32'd0);
        check_val("flush_err",  32'(err), 32'd0);
        check_val("flush_load", 32'(load), 32'd0);
        send(4'h7, 1'b0);
        check_val("flush_err1", 32'(err), 32'd0);
        send(4'h8, 1'b0);
        send(4'h9, 1'b0);
        check_val("flush_err3", 32'(err), 32'd0);
        send(4'hA, 1'b1);
        check_val("flush_next_load", 32'(load), 32'd1);
        check_val("flush_next_vec",  32'(vec_out), 32'hA987);
        check_val("flush_next_err",  32'(err), 32'd0);
        tick();

        // Reset mid-vector after 3 accepts
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        reset = 1'b0;
        tick();
        check_val("mid_rst_busy",  32'(busy), 32'd0);
        check_val("mid_rst_vec",   32'(vec_out), 32'd0);
        check_val("mid_rst_load",  32'(load), 32'd0);
        check_val("mid_rst_err",   32'(err), 32'd0);
        check_val("mid_rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        tick();
        check_val("mid_rst_noload", 32'(load), 32'd0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        send(4'hD, 1'b0);
        check_val("mid_rst_partial", 32'(vec_out), 32'h0DCB);
        check_val("mid_rst_nold",    32'(load), 32'd0);
        send(4'hE, 1'b1);
        check_val("mid_rst_load2", 32'(load), 32'd1);
        check_val("mid_rst_vec2",  32'(vec_out), 32'hEDCB);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
